// File: rtl/seg_pkg.sv
// Shared types, default parameters and helpers for the seven-segment scan controller.
package seg_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_SLOT_CYC   = 1000;
    localparam int DEF_GUARD_CYC  = 16;

    // nib_sel works on a fixed-width vector wide enough for the largest supported display.
    localparam int MAX_DIGITS = 16;
    localparam int NIB_VEC_W  = 4 * MAX_DIGITS;

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [0:0] S_GUARD = GUARD;
    localparam logic [0:0] S_DRIVE = DRIVE;

    function automatic logic [3:0] nib_sel(input logic [NIB_VEC_W-1:0] vec,
                                           input logic [3:0]           idx);
        return vec[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot and digit counters for the scan controller; counters sit at zero whenever advance is low.
module seg_slot_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 1000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_nxt,
    output logic                          guard_end,
    output logic                          slot_end,
    output logic                          frame_wrap
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;

    assign guard_end  = advance && (cnt == GUARD_LAST);
    assign slot_end   = advance && (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    always_comb begin
        idx_nxt = idx;
        if (slot_end) begin
            idx_nxt = frame_wrap ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!advance) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex digit scanner with double-buffered value and an all-off guard per slot.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SLOT_CYC   = DEF_SLOT_CYC,
    parameter int GUARD_CYC  = DEF_GUARD_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    output logic [3:0]              nibble_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_start_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int W     = 4 * NUM_DIGITS;

    logic [W-1:0]          shadow;
    logic [W-1:0]          active;
    logic [W-1:0]          active_n;
    logic                  pending;
    logic                  run;
    logic [0:0]            state;
    logic [0:0]            state_n;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  guard_end;
    logic                  slot_end;
    logic                  frame_wrap;
    logic                  start;
    logic                  advance;
    logic                  boundary;
    logic                  slot_begin;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_n;

    // run remembers that the previous edge saw en high, so start marks the first enabled edge.
    assign start      = en && !run;
    assign advance    = en && run;
    assign boundary   = start || frame_wrap;
    assign slot_begin = start || slot_end;

    seg_slot_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .SLOT_CYC  (SLOT_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .idx       (idx),
        .idx_nxt   (idx_nxt),
        .guard_end (guard_end),
        .slot_end  (slot_end),
        .frame_wrap(frame_wrap)
    );

    always_comb begin
        active_n = active;
        if (boundary) begin
            if (load_i) begin
                active_n = value_i;
            end else if (pending) begin
                active_n = shadow;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (!advance || slot_end) begin
            state_n = S_GUARD;
        end else if (guard_end) begin
            state_n = S_DRIVE;
        end
    end

    always_comb begin
        an_n = '1;
        if (state_n == S_DRIVE && !blank[idx]) begin
            an_n = ~(NUM_DIGITS'(1) << idx);
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] blank_n;
    logic                  zero_run;

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_n  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (active_n[4*k +: 4] == 4'h0);
            blank_n[k] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank <= '0;
        end else if (boundary) begin
            blank <= blank_n;
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run           <= 1'b0;
            state         <= S_GUARD;
            shadow        <= '0;
            active        <= '0;
            pending       <= 1'b0;
            nibble_o      <= 4'h0;
            an_o          <= '1;
            frame_start_o <= 1'b0;
        end else begin
            run           <= en;
            state         <= state_n;
            active        <= active_n;
            an_o          <= an_n;
            frame_start_o <= boundary;
            if (load_i) begin
                shadow <= value_i;
            end
            if (boundary) begin
                pending <= 1'b0;
            end else if (load_i) begin
                pending <= 1'b1;
            end
            // The nibble changes only as a slot opens, while the guard keeps every digit dark.
            if (slot_begin) begin
                nibble_o <= nib_sel(NIB_VEC_W'(active_n), 4'(idx_nxt));
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots and a 2-cycle guard.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * SC;

`ifdef SEG_SCAN_LZB_EN
    localparam logic [3:0] ZB    = 4'b1110;
    localparam logic [3:0] B00B0 = 4'b1100;
`else
    localparam logic [3:0] ZB    = 4'b0000;
    localparam logic [3:0] B00B0 = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  nibble_o;
    logic [3:0]  an_o;
    logic        frame_start_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SLOT_CYC  (SC),
        .GUARD_CYC (GC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .value_i      (value_i),
        .load_i       (load_i),
        .nibble_o     (nibble_o),
        .an_o         (an_o),
        .frame_start_o(frame_start_o)
    );

    // One record per frame: what the frame must show, and loads to apply while it runs.
    typedef struct {
        string       name;
        logic [15:0] digits;
        logic [3:0]  blank;
        int          load_pos;
        logic [15:0] load_val;
        int          load_pos2;
        logic [15:0] load_val2;
    } frame_vec_t;

    frame_vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input frame_vec_t v);
        for (int p = 0; p < FRAME; p++) begin
            int         s;
            int         c;
            logic [3:0] exp_an;
            logic [3:0] exp_nib;
            s = p / SC;
            c = p % SC;
            @(negedge clk);
            exp_an  = (c < GC || v.blank[s]) ? 4'hF : ~(4'b0001 << s);
            exp_nib = v.digits[4*s +: 4];
            chk({v.name, " frame_start"}, 16'(frame_start_o), 16'(p == 0));
            chk({v.name, " an"}, 16'(an_o), 16'(exp_an));
            chk({v.name, " nibble"}, 16'(nibble_o), 16'(exp_nib));
            load_i = 1'b0;
            if (p == v.load_pos) begin
                load_i  = 1'b1;
                value_i = v.load_val;
            end
            if (p == v.load_pos2) begin
                load_i  = 1'b1;
                value_i = v.load_val2;
            end
        end
    endtask

    initial begin
        vecs[0] = '{"idle",          16'h0000, ZB,      10, 16'h1A2F, -1, 16'h0000};
        vecs[1] = '{"load_mid",      16'h1A2F, 4'b0000,  5, 16'h1111, 20, 16'h2222};
        vecs[2] = '{"two_loads",     16'h2222, 4'b0000, 31, 16'h00B0, -1, 16'h0000};
        vecs[3] = '{"boundary_load", 16'h00B0, B00B0,   -1, 16'h0000, -1, 16'h0000};
        vecs[4] = '{"no_reload",     16'h00B0, B00B0,    0, 16'h8001, -1, 16'h0000};
        vecs[5] = '{"late_load",     16'h8001, 4'b0000, -1, 16'h0000, -1, 16'h0000};

        rst     = 1'b1;
        en      = 1'b0;
        load_i  = 1'b0;
        value_i = 16'h0000;

        repeat (2) @(negedge clk);
        chk("reset an", 16'(an_o), 16'h000F);
        chk("reset nibble", 16'(nibble_o), 16'h0000);
        chk("reset frame_start", 16'(frame_start_o), 16'h0000);
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        // Drop en in the DRIVE window of digit 2, load while dark, then re-enable.
        for (int p = 0; p <= 20; p++) begin
            @(negedge clk);
            load_i = 1'b0;
        end
        chk("digit2 drive an", 16'(an_o), 16'h000B);
        chk("digit2 drive nibble", 16'(nibble_o), 16'h0000);
        en = 1'b0;
        @(negedge clk);
        chk("en_low an", 16'(an_o), 16'h000F);
        chk("en_low frame_start", 16'(frame_start_o), 16'h0000);
        load_i  = 1'b1;
        value_i = 16'h5678;
        @(negedge clk);
        load_i = 1'b0;
        chk("en_low hold an", 16'(an_o), 16'h000F);
        @(negedge clk);
        chk("en_low hold2 an", 16'(an_o), 16'h000F);
        en = 1'b1;
        @(negedge clk);
        chk("en_rise frame_start", 16'(frame_start_o), 16'h0001);
        chk("en_rise an", 16'(an_o), 16'h000F);
        chk("en_rise nibble", 16'(nibble_o), 16'h0008);
        @(negedge clk);
        chk("en_rise guard2 frame_start", 16'(frame_start_o), 16'h0000);
        chk("en_rise guard2 an", 16'(an_o), 16'h000F);
        @(negedge clk);
        chk("en_rise drive an", 16'(an_o), 16'h000E);
        chk("en_rise drive nibble", 16'(nibble_o), 16'h0008);
        @(negedge clk);
        chk("pre_reset an", 16'(an_o), 16'h000E);

        // Reset between clock edges must clear the outputs at once.
        #2 rst = 1'b1;
        #1;
        chk("async_reset an", 16'(an_o), 16'h000F);
        chk("async_reset nibble", 16'(nibble_o), 16'h0000);
        chk("async_reset frame_start", 16'(frame_start_o), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame('{"after_reset", 16'h0000, ZB, -1, 16'h0000, -1, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
